// File: rtl/memory_scan_controller_pkg.sv
// ---------------------------------------------------------------------------
// memory_scan_controller_pkg
//
// Purpose:
//   Shared definitions for the memory bank scan controller: chain geometry
//   and the controller state encoding. Imported by the controller top and by
//   its byte serialiser/deserialiser.
//
// Contents:
//   SCAN_CHAIN_LEN   total number of scan bits (31 memory bytes, 1 button
//                    bit, 7 LED bits)
//   SCAN_BYTE_WIDTH  width of one stream byte
//   SCAN_BYTES       number of stream bytes per full session
//   scan_state_t     controller FSM state encoding
// ---------------------------------------------------------------------------
package memory_scan_controller_pkg;

    localparam int SCAN_CHAIN_LEN  = 256;
    localparam int SCAN_BYTE_WIDTH = 8;
    localparam int SCAN_BYTES      = SCAN_CHAIN_LEN / SCAN_BYTE_WIDTH;

    // IDLE    : no session, CPU free to run
    // WAIT_IN : session open, waiting for the next input byte
    // SHIFT   : serialising the current byte into the chain
    // FINISH  : all bits shifted, draining the last captured byte
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IN = 2'd1,
        SHIFT   = 2'd2,
        FINISH  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/memory_scan_controller_serdes.sv
// ---------------------------------------------------------------------------
// scan_byte_serdes
//
// Purpose:
//   Byte-wide serialiser/deserialiser for the scan chain. Holds the transmit
//   shift register (MSB drives scan_in), the receive shift register (fills
//   from the LSB with the bit leaving the chain) and the bit counter that
//   marks the last bit of each byte.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active low
//   load       in   load load_data into tx and restart the bit counter
//   load_data  in   byte to serialise, MSB first
//   shift      in   chain shifts on this edge (same as the bank scan_enable)
//   scan_out   in   bit currently at the chain output
//   scan_in    out  bit presented to the chain input (tx MSB, registered)
//   rx_next    out  receive byte including the bit sampled on this edge
//   last_bit   out  the current bit is the 8th bit of the byte
// ---------------------------------------------------------------------------
module scan_byte_serdes
    import memory_scan_controller_pkg::*;
#(
    parameter int BYTE_WIDTH = SCAN_BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BYTE_WIDTH-1:0] load_data,
    input  logic                  shift,
    input  logic                  scan_out,
    output logic                  scan_in,
    output logic [BYTE_WIDTH-1:0] rx_next,
    output logic                  last_bit
);

    localparam int BIT_CNT_WIDTH = $clog2(BYTE_WIDTH);

    logic [BYTE_WIDTH-1:0]    tx;
    logic [BYTE_WIDTH-1:0]    rx;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt;

    assign scan_in  = tx[BYTE_WIDTH-1];
    assign rx_next  = {rx[BYTE_WIDTH-2:0], scan_out};
    assign last_bit = (bit_cnt == '0);

    // Transmit register. A load wins over a shift so that the next byte can be
    // accepted on the very edge that shifts out the last bit of the current
    // one; the chain has already sampled the old MSB on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx <= '0;
        end else if (load) begin
            tx <= load_data;
        end else if (shift) begin
            tx <= {tx[BYTE_WIDTH-2:0], 1'b0};
        end
    end

    // Receive register. Every chain shift samples the bit leaving the chain
    // before it moves, so after eight shifts the first bit out sits in the MSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx <= '0;
        end else if (shift) begin
            rx <= rx_next;
        end
    end

    // Bit counter. Counts down from 7 to 0 and parks at 0 between bytes, so
    // last_bit is also the "no byte in flight" indication used for stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
        end else if (load) begin
            bit_cnt <= BIT_CNT_WIDTH'(BYTE_WIDTH - 1);
        end else if (shift && !last_bit) begin
            bit_cnt <= bit_cnt - BIT_CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/memory_scan_controller.sv
// ---------------------------------------------------------------------------
// memory_scan_controller
//
// Purpose:
//   Runs one load/readback session over the memory bank scan chain. A byte
//   stream arriving on the in_* handshake is shifted serially into the chain
//   (stream bit 0 enters first) while the bits falling out of the chain are
//   packed into bytes and returned on the out_* handshake. The CPU is held
//   for as long as busy is high.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   start        in   one-cycle pulse that opens a session (ignored if busy)
//   abort        in   synchronous cancel of the running session
//   in_data      in   byte to shift in, MSB first
//   in_valid     in   in_data is valid
//   in_ready     out  controller takes in_data this cycle
//   out_data     out  captured byte, MSB = first bit out of the chain
//   out_valid    out  out_data is valid (held until out_ready)
//   out_ready    in   consumer takes out_data
//   scan_enable  out  bank scan_enable
//   scan_in      out  bank scan_in
//   scan_out     in   bank scan_out
//   busy         out  session active, CPU must stall
//   done         out  one-cycle pulse when a session completes
// ---------------------------------------------------------------------------
module memory_scan_controller
    import memory_scan_controller_pkg::*;
#(
    parameter int CHAIN_LEN      = SCAN_CHAIN_LEN,
    parameter int BYTE_WIDTH     = SCAN_BYTE_WIDTH,
    parameter int BYTE_CNT_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BYTE_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  scan_enable,
    output logic                  scan_in,
    input  logic                  scan_out,
    output logic                  busy,
    output logic                  done
);

    localparam int NUM_BYTES = CHAIN_LEN / BYTE_WIDTH;
    localparam logic [BYTE_CNT_WIDTH-1:0] LAST_BYTE = BYTE_CNT_WIDTH'(NUM_BYTES - 1);

    scan_state_t state;
    scan_state_t state_next;

    logic [BYTE_CNT_WIDTH-1:0] byte_cnt;
    logic [BYTE_WIDTH-1:0]     rx_next;
    logic                      last_bit;
    logic                      last_byte;
    logic                      stall;
    logic                      load_byte;
    logic                      capture;

    // The 8th bit may only shift when the holding register can take the new
    // byte; otherwise the chain freezes on that bit until the consumer drains
    // out_data. This makes scan_enable combinational in out_ready.
    assign stall     = last_bit && out_valid && !out_ready;
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign load_byte = in_valid && in_ready;
    assign capture   = scan_enable && last_bit;

    scan_byte_serdes #(
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_serdes (
        .clk       (clk),
        .rst       (rst),
        .load      (load_byte),
        .load_data (in_data),
        .shift     (scan_enable),
        .scan_out  (scan_out),
        .scan_in   (scan_in),
        .rx_next   (rx_next),
        .last_bit  (last_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. abort beats everything, including a
    // start seen in the same cycle, and kills scan_enable straight away so the
    // chain does not move on the cancelling edge. In SHIFT the next byte is
    // offered in_ready on the 8th shift so a continuous stream runs with no
    // idle cycle between bytes.
    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        scan_enable = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_next = WAIT_IN;
                end
            end

            WAIT_IN: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    in_ready = !out_valid || out_ready;
                    if (in_valid && in_ready) begin
                        state_next = SHIFT;
                    end
                end
            end

            SHIFT: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    scan_enable = !stall;
                    if (scan_enable && last_bit) begin
                        if (last_byte) begin
                            state_next = FINISH;
                        end else begin
                            in_ready = 1'b1;
                            if (!in_valid) begin
                                state_next = WAIT_IN;
                            end
                        end
                    end
                end
            end

            FINISH: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = IDLE;
                end else if (!out_valid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte counter. Held at zero while idle so every session starts from the
    // first byte; counts each completed byte as it is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
        end else if (state == IDLE) begin
            byte_cnt <= '0;
        end else if (capture) begin
            byte_cnt <= byte_cnt + BYTE_CNT_WIDTH'(1);
        end
    end

    // Output holding register. A capture always lands here because the stall
    // guarantees the slot is empty or being drained on that same edge; a
    // drain without a capture empties it. An abort discards whatever is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (abort && busy) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= rx_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_memory_scan_controller
//
// Purpose:
//   Directed bench for memory_scan_controller. A behavioural 256-bit scan
//   chain stands in for the memory bank; chain[255] is the scan_out (LED) end
//   and memory byte j sits at chain[8j+7:8j]. Inputs are driven on the
//   falling edge and outputs sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_memory_scan_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic       busy;
    logic       done;

    logic [255:0] chain = '0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    int tests_run    = 0;
    int tests_failed = 0;

    int cycle = 0;
    int se_count, first_se, last_se, gap_count, stall_ready_count;
    int done_count, done_cycle, accepted, since_acc;
    int gap_after, gap_left, hold_at, hold_left, busy_start_at, abort_at;
    bit start_now, abort_fired, abort_se;

    memory_scan_controller dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Behavioural memory bank scan chain.
    assign scan_out = chain[255];

    always @(posedge clk) begin
        if (scan_enable) begin
            chain <= {chain[254:0], scan_in};
        end
    end

    // Hard stop in case a wait is ever left unbounded.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Stream byte k is expected at chain[255-8k -: 8]; readback uses the same placement.
    function automatic logic [255:0] pack_stream(input logic [7:0] s[$]);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 32 && k < s.size(); k++) begin
            v[255-8*k -: 8] = s[k];
        end
        return v;
    endfunction

    task automatic clear_stats();
        se_count          = 0;
        first_se          = -1;
        last_se           = -1;
        gap_count         = 0;
        stall_ready_count = 0;
        done_count        = 0;
        done_cycle        = -1;
        accepted          = 0;
        since_acc         = 0;
        gap_after         = -1;
        gap_left          = 0;
        hold_at           = -1;
        hold_left         = 0;
        busy_start_at     = -1;
        abort_at          = -1;
        abort_fired       = 1'b0;
        abort_se          = 1'b1;
        rx_q.delete();
    endtask

    // One clock: drive the source/sink/control inputs, then sample the
    // handshakes and scan activity for this cycle.
    task automatic applyStimulus();
        @(negedge clk);
        if (gap_after >= 0 && accepted == gap_after && since_acc == 7) begin
            gap_left  = 5;
            gap_after = -1;
        end
        in_valid = (tx_q.size() > 0) && (gap_left == 0);
        in_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        if (gap_left > 0) gap_left--;
        out_ready = 1'b1;
        if (hold_at >= 0 && rx_q.size() == hold_at && out_valid && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
        end
        start = start_now || (busy_start_at >= 0 && se_count == busy_start_at);
        if (busy_start_at >= 0 && se_count == busy_start_at) busy_start_at = -1;
        start_now = 1'b0;
        abort = (abort_at >= 0 && se_count == abort_at);
        if (abort) begin
            abort_at    = -1;
            abort_fired = 1'b1;
        end
        #1;
        if (abort) abort_se = scan_enable;
        if (in_valid && in_ready) begin
            void'(tx_q.pop_front());
            accepted++;
            since_acc = 0;
        end else begin
            since_acc++;
        end
        if (out_valid && out_ready) rx_q.push_back(out_data);
        if (scan_enable) begin
            se_count++;
            if (first_se < 0) first_se = cycle;
            last_se = cycle;
        end else if (busy && se_count > 0 && se_count < 256) begin
            gap_count++;
            if (in_ready) stall_ready_count++;
        end
        if (done) begin
            done_count++;
            done_cycle = cycle;
        end
        cycle++;
    endtask

    // Start a session with whatever is queued in tx_q and run until done
    // (bounded), plus a short tail to catch stray done pulses.
    task automatic run_session(input int max_cycles, output bit finished);
        finished  = 1'b0;
        start_now = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            applyStimulus();
            if (done_count > 0) begin
                finished = 1'b1;
                break;
            end
        end
        repeat (3) applyStimulus();
    endtask

    initial begin
        logic [7:0] s_count[$];
        logic [7:0] s_a5[$];
        logic [7:0] s_three[$];
        logic [7:0] s_four[$];
        logic [7:0] s_abort[$];
        bit         fin;

        for (int k = 0; k < 32; k++) begin
            s_count.push_back(8'(k));
            s_a5.push_back(8'hA5);
            s_three.push_back(8'(k * 9 + 3));
            s_four.push_back(8'(255 - k * 5));
            s_abort.push_back(8'h5A);
        end

        rst       = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        clear_stats();
        #2 rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("reset_outputs", {scan_enable, scan_in, busy, done, in_ready, out_valid, out_data}, '0);
        @(negedge clk);
        rst = 1'b1;

        // Session 1: load 0x00..0x1F back to back into an all-zero chain.
        clear_stats();
        tx_q = s_count;
        run_session(1000, fin);
        checkOutput("s1_finished", 256'(fin), 256'(1));
        checkOutput("s1_shift_count", 256'(se_count), 256'(256));
        checkOutput("s1_no_gaps", 256'(last_se - first_se + 1), 256'(256));
        checkOutput("s1_done_timing", 256'(done_cycle), 256'(last_se + 2));
        checkOutput("s1_done_pulses", 256'(done_count), 256'(1));
        checkOutput("s1_readback", pack_stream(rx_q), '0);
        checkOutput("s1_mem0", 256'(chain[7:0]), 256'(8'h1F));
        checkOutput("s1_mem30", 256'(chain[247:240]), 256'(8'h01));
        checkOutput("s1_led_button", 256'(chain[255:248]), 256'(8'h00));

        // Session 2: stream 0xA5 x32, read back the previous load.
        clear_stats();
        tx_q = s_a5;
        run_session(1000, fin);
        checkOutput("s2_finished", 256'(fin), 256'(1));
        checkOutput("s2_readback_count", 256'(rx_q.size()), 256'(32));
        checkOutput("s2_readback", pack_stream(rx_q), pack_stream(s_count));
        checkOutput("s2_chain", chain, {32{8'hA5}});

        // Session 3: hold out_ready low while byte 3 sits in out_data.
        clear_stats();
        hold_at   = 3;
        hold_left = 20;
        tx_q      = s_three;
        run_session(1000, fin);
        checkOutput("s3_finished", 256'(fin), 256'(1));
        checkOutput("s3_shift_count", 256'(se_count), 256'(256));
        checkOutput("s3_stall_cycles", 256'(gap_count), 256'(13));
        checkOutput("s3_in_ready_in_stall", 256'(stall_ready_count), 256'(0));
        checkOutput("s3_readback", pack_stream(rx_q), {32{8'hA5}});
        checkOutput("s3_chain", chain, pack_stream(s_three));

        // Session 4: 5-cycle in_valid gap after byte 15, plus a start while busy.
        clear_stats();
        gap_after     = 16;
        busy_start_at = 50;
        tx_q          = s_four;
        run_session(1000, fin);
        checkOutput("s4_finished", 256'(fin), 256'(1));
        checkOutput("s4_shift_count", 256'(se_count), 256'(256));
        checkOutput("s4_gap_cycles", 256'(gap_count), 256'(5));
        checkOutput("s4_done_pulses", 256'(done_count), 256'(1));
        checkOutput("s4_readback", pack_stream(rx_q), pack_stream(s_three));
        checkOutput("s4_chain", chain, pack_stream(s_four));

        // Session 5: abort after 100 shifts.
        clear_stats();
        abort_at  = 100;
        tx_q      = s_abort;
        start_now = 1'b1;
        for (int c = 0; c < 400 && !abort_fired; c++) applyStimulus();
        checkOutput("s5_abort_fired", 256'(abort_fired), 256'(1));
        checkOutput("s5_abort_scan_enable", 256'(abort_se), 256'(0));
        tx_q.delete();
        applyStimulus();
        checkOutput("s5_idle_after_abort", 256'({busy, out_valid, in_ready}), 256'(0));
        repeat (10) applyStimulus();
        checkOutput("s5_no_done", 256'(done_count), 256'(0));
        checkOutput("s5_shift_count", 256'(se_count), 256'(100));

        // Session 6: reset in the middle of a byte, then a clean session.
        clear_stats();
        tx_q      = s_count;
        start_now = 1'b1;
        for (int c = 0; c < 400 && se_count < 37; c++) applyStimulus();
        checkOutput("s6_reached_mid_byte", 256'(se_count), 256'(37));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("s6_reset_outputs", {scan_enable, scan_in, busy, done, in_ready, out_valid, out_data}, '0);
        tx_q.delete();
        repeat (2) applyStimulus();
        rst = 1'b1;
        clear_stats();
        tx_q = s_count;
        run_session(1000, fin);
        checkOutput("s6_finished", 256'(fin), 256'(1));
        checkOutput("s6_shift_count", 256'(se_count), 256'(256));
        checkOutput("s6_done_pulses", 256'(done_count), 256'(1));
        checkOutput("s6_mem0", 256'(chain[7:0]), 256'(8'h1F));
        checkOutput("s6_mem30", 256'(chain[247:240]), 256'(8'h01));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
